// File: rtl/cfg_mem_sequencer_pkg.sv
// Shared types and sizing for the CGRA tile configuration sequencer.
package cfg_mem_sequencer_pkg;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic        predicate;
        logic [11:0] fu_in;
        logic [23:0] outport;
        logic [5:0]  predicate_in;
    } CGRAConfig_6_4_6_8;

    localparam int NUM_CFG = 4;
    localparam int ADDR_W  = $clog2(NUM_CFG);
    localparam int CFG_W   = $bits(CGRAConfig_6_4_6_8);
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cfg_mem_sequencer_if.sv
// Config stream, register-file port and FU config output of one tile sequencer.
interface cfg_mem_sequencer_if;
    import cfg_mem_sequencer_pkg::*;

    logic [CFG_W-1:0]  recv_msg;
    logic              recv_val;
    logic              recv_rdy;
    logic [ADDR_W-1:0] rf_waddr;
    logic [CFG_W-1:0]  rf_wdata;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_raddr;
    logic [CFG_W-1:0]  rf_rdata;
    logic              advance;
    logic [CFG_W-1:0]  cfg_out;
    logic              cfg_val;

    modport master (
        input  recv_msg, recv_val, rf_rdata, advance,
        output recv_rdy, rf_waddr, rf_wdata, rf_wen, rf_raddr, cfg_out, cfg_val
    );

    modport slave (
        output recv_msg, recv_val, rf_rdata, advance,
        input  recv_rdy, rf_waddr, rf_wdata, rf_wen, rf_raddr, cfg_out, cfg_val
    );

endinterface

// File: rtl/cfg_mem_sequencer.sv
// Loads num_cfg config words into the tile register file, then replays them to the FU, one per advance.
// Latency: write lands at the handshake edge; cfg_out follows rf_rdata with zero added latency.
// Backpressure: recv_rdy only in LOAD and dropped combinationally by stop; advance gates read-pointer stepping.
module cfg_mem_sequencer
    import cfg_mem_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     num_cfg,
    input  logic                stop,
    cfg_mem_sequencer_if.master bus,
    output logic [CNT_W-1:0]    iter_count,
    output logic                cfg_err
);

    seq_state_t        state;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;

    logic [ADDR_W:0]   last_idx;
    logic              num_legal;
    logic              last_wr;
    logic              last_rd;
    logic              in_run;

    assign last_idx  = num_q - (ADDR_W+1)'(1);
    assign num_legal = (num_cfg != '0) && (num_cfg <= (ADDR_W+1)'(NUM_CFG));
    assign last_wr   = ({1'b0, wptr} == last_idx);
    assign last_rd   = ({1'b0, rptr} == last_idx);
    assign in_run    = (state == RUN);

    // stop must block a coincident handshake, so ready is qualified here rather than registered
    assign bus.recv_rdy = (state == LOAD) && !stop;
    assign bus.rf_wen   = bus.recv_val && bus.recv_rdy;
    assign bus.rf_waddr = wptr;
    assign bus.rf_wdata = bus.recv_msg;
    assign bus.rf_raddr = in_run ? rptr : '0;
    assign bus.cfg_out  = in_run ? bus.rf_rdata : '0;
    assign bus.cfg_val  = in_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            num_q      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            iter_count <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_legal) begin
                            num_q <= num_cfg;
                            wptr  <= '0;
                            state <= LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (bus.rf_wen) begin
                        wptr <= wptr + ADDR_W'(1);
                        if (last_wr) begin
                            rptr       <= '0;
                            iter_count <= '0;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (bus.advance) begin
                        if (last_rd) begin
                            rptr       <= '0;
                            iter_count <= iter_count + CNT_W'(1);
                        end else begin
                            rptr <= rptr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
